// File: rtl/chip8_cpu.sv
// CHIP-8 interpreter core: fetches big-endian opcodes over a shared byte port,
// owns registers, call stack, 64x32 framebuffer and the 60 Hz delay/sound timers.
module chip8_cpu #(
  parameter int TIMER_DIV = 833333
) (
  input  logic        clk,
  input  logic        reset,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_write_data,
  output logic        mem_write_en,
  input  logic [7:0]  mem_read_data,
  output logic        display_update,
  output logic [7:0]  delay_timer_out,
  output logic [7:0]  sound_timer_out,
  output logic [2:0]  o_dbg_state
);

  typedef enum logic [2:0] {FETCH_HI, FETCH_LO, EXEC, DRAW, REGMEM} state_t;
  state_t state, w_next;

  logic [11:0] pc;
  logic [7:0]  V [0:15];
  logic [11:0] I;
  logic [3:0]  sp;
  logic [11:0] stack [0:15];
  logic [63:0] display_pixels [0:31];

  logic [15:0] r_opcode;
  logic [3:0]  r_cnt;
  logic [5:0]  r_dx;
  logic [4:0]  r_dy;
  logic        r_disp;
  logic [7:0]  r_delay, r_sound;
  logic [31:0] r_div;

  logic [3:0]   w_x, w_y, w_n, w_sp_dec;
  logic [7:0]   w_nn, w_vx, w_vy;
  logic [11:0]  w_nnn;
  logic [8:0]   w_sum;
  logic         w_tick, w_is_regmem;
  logic [4:0]   w_row;
  logic [127:0] w_dbl;
  logic [63:0]  w_mask;

  assign w_x         = r_opcode[11:8];
  assign w_y         = r_opcode[7:4];
  assign w_n         = r_opcode[3:0];
  assign w_nn        = r_opcode[7:0];
  assign w_nnn       = r_opcode[11:0];
  assign w_vx        = V[w_x];
  assign w_vy        = V[w_y];
  assign w_sum       = {1'b0, w_vx} + {1'b0, w_vy};
  assign w_sp_dec    = sp - 4'd1;
  assign w_tick      = (r_div == 32'(TIMER_DIV - 1));
  assign w_is_regmem = (r_opcode[15:12] == 4'hF) && (w_nn == 8'h55 || w_nn == 8'h65);
  assign w_row       = r_dy + {1'b0, r_cnt};
  // Rotating the doubled sprite byte wraps columns past 63 back to column 0.
  assign w_dbl       = {mem_read_data, 56'd0, mem_read_data, 56'd0} >> r_dx;
  assign w_mask      = w_dbl[63:0];

  assign display_update  = r_disp;
  assign delay_timer_out = r_delay;
  assign sound_timer_out = r_sound;
  assign o_dbg_state     = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH_HI;
    else        state <= w_next;
  end

  always_comb begin
    w_next = state;
    case (state)
      FETCH_HI: w_next = FETCH_LO;
      FETCH_LO: w_next = EXEC;
      EXEC: begin
        if (r_opcode[15:12] == 4'hD) w_next = DRAW;
        else if (w_is_regmem)        w_next = REGMEM;
        else                         w_next = FETCH_HI;
      end
      DRAW:    if (r_cnt == w_n) w_next = FETCH_HI;
      REGMEM:  if (r_cnt == w_x) w_next = FETCH_HI;
      default: w_next = FETCH_HI;
    endcase
  end

  always_comb begin
    mem_addr = pc;
    case (state)
      FETCH_LO:     mem_addr = pc + 12'd1;
      DRAW, REGMEM: mem_addr = I + {8'd0, r_cnt};
      default:      mem_addr = pc;
    endcase
    mem_write_en   = (state == REGMEM) && (w_nn == 8'h55);
    mem_write_data = mem_write_en ? V[r_cnt] : 8'd0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= 12'h200;
      I        <= '0;
      sp       <= '0;
      r_opcode <= '0;
      r_cnt    <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_disp   <= 1'b0;
      r_delay  <= '0;
      r_sound  <= '0;
      r_div    <= '0;
      for (int k = 0; k < 16; k++) begin
        V[k]     <= '0;
        stack[k] <= '0;
      end
      for (int k = 0; k < 32; k++) display_pixels[k] <= '0;
    end else begin
      r_disp <= 1'b0;
      r_div  <= w_tick ? 32'd0 : r_div + 32'd1;
      // Tick decrements come first so an FX15/FX18 in the same cycle overrides them.
      if (w_tick) begin
        if (r_delay != 8'd0) r_delay <= r_delay - 8'd1;
        if (r_sound != 8'd0) r_sound <= r_sound - 8'd1;
      end
      case (state)
        FETCH_HI: r_opcode[15:8] <= mem_read_data;
        FETCH_LO: r_opcode[7:0]  <= mem_read_data;
        EXEC: begin
          pc    <= pc + 12'd2;
          r_cnt <= '0;
          case (r_opcode[15:12])
            4'h0: begin
              if (w_nnn == 12'h0E0) begin
                for (int k = 0; k < 32; k++) display_pixels[k] <= '0;
                r_disp <= 1'b1;
              end else if (w_nnn == 12'h0EE) begin
                sp <= w_sp_dec;
                pc <= stack[w_sp_dec] + 12'd2;
              end
            end
            4'h1: pc <= w_nnn;
            4'h2: begin
              stack[sp] <= pc;
              sp        <= sp + 4'd1;
              pc        <= w_nnn;
            end
            4'h3: if (w_vx == w_nn) pc <= pc + 12'd4;
            4'h4: if (w_vx != w_nn) pc <= pc + 12'd4;
            4'h5: if (w_n == 4'h0 && w_vx == w_vy) pc <= pc + 12'd4;
            4'h6: V[w_x] <= w_nn;
            4'h7: V[w_x] <= w_vx + w_nn;
            // Flag writes follow the result so VF holds the flag when X is F.
            4'h8: begin
              case (w_n)
                4'h0: V[w_x] <= w_vy;
                4'h1: V[w_x] <= w_vx | w_vy;
                4'h2: V[w_x] <= w_vx & w_vy;
                4'h3: V[w_x] <= w_vx ^ w_vy;
                4'h4: begin V[w_x] <= w_sum[7:0];   V[15] <= {7'd0, w_sum[8]};       end
                4'h5: begin V[w_x] <= w_vx - w_vy;  V[15] <= {7'd0, (w_vx >= w_vy)}; end
                4'h6: begin V[w_x] <= w_vx >> 1;    V[15] <= {7'd0, w_vx[0]};        end
                4'h7: begin V[w_x] <= w_vy - w_vx;  V[15] <= {7'd0, (w_vy >= w_vx)}; end
                4'hE: begin V[w_x] <= w_vx << 1;    V[15] <= {7'd0, w_vx[7]};        end
                default: ;
              endcase
            end
            4'h9: if (w_n == 4'h0 && w_vx != w_vy) pc <= pc + 12'd4;
            4'hA: I <= w_nnn;
            4'hB: pc <= w_nnn + {4'd0, V[0]};
            4'hD: begin
              r_dx  <= w_vx[5:0];
              r_dy  <= w_vy[4:0];
              V[15] <= 8'd0;
            end
            4'hF: begin
              case (w_nn)
                8'h1E: I       <= I + {4'd0, w_vx};
                8'h07: V[w_x]  <= r_delay;
                8'h15: r_delay <= w_vx;
                8'h18: r_sound <= w_vx;
                default: ;
              endcase
            end
            default: ;
          endcase
        end
        DRAW: begin
          if (r_cnt != w_n) begin
            display_pixels[w_row] <= display_pixels[w_row] ^ w_mask;
            if (|(display_pixels[w_row] & w_mask)) V[15] <= 8'd1;
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt + 4'd1 == w_n) r_disp <= 1'b1;
          end
        end
        REGMEM: begin
          if (w_nn == 8'h65) V[r_cnt] <= mem_read_data;
          r_cnt <= r_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_cpu.sv
// Directed program runs against chip8_cpu with a byte memory model; expected
// values are queued per program and popped at each checkpoint.
module tb_chip8_cpu;

  logic        clk;
  logic        reset;
  logic [11:0] mem_addr;
  logic [7:0]  mem_write_data;
  logic        mem_write_en;
  logic [7:0]  mem_read_data;
  logic        display_update;
  logic [7:0]  delay_timer_out;
  logic [7:0]  sound_timer_out;
  logic [2:0]  dbg_state;

  logic [7:0]  mem [0:4095];
  logic [7:0]  ld_img [0:4095];
  logic        ld_en;
  int          pulse_cnt, wr_cnt, base_pulse, base_wr;
  int          vectors, miscompares;
  logic [63:0] exp_q [$];

  chip8_cpu #(.TIMER_DIV(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_addr        (mem_addr),
    .mem_write_data  (mem_write_data),
    .mem_write_en    (mem_write_en),
    .mem_read_data   (mem_read_data),
    .display_update  (display_update),
    .delay_timer_out (delay_timer_out),
    .sound_timer_out (sound_timer_out),
    .o_dbg_state     (dbg_state)
  );

  // clock / memory / event counters
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_read_data = mem[mem_addr];

  always @(posedge clk) begin
    if (ld_en) begin
      for (int k = 0; k < 4096; k++) mem[k] <= ld_img[k];
    end else if (mem_write_en) begin
      mem[mem_addr] <= mem_write_data;
    end
  end

  initial begin
    pulse_cnt = 0;
    wr_cnt    = 0;
  end

  always @(negedge clk) begin
    if (display_update === 1'b1) pulse_cnt = pulse_cnt + 1;
    if (mem_write_en === 1'b1)   wr_cnt = wr_cnt + 1;
  end

  // driver tasks
  task automatic begin_test();
    reset = 1'b0;
    for (int k = 0; k < 4096; k++) ld_img[k] = 8'h00;
  endtask

  task automatic poke(input logic [11:0] a, input logic [15:0] w);
    ld_img[a]         = w[15:8];
    ld_img[a + 12'd1] = w[7:0];
  endtask

  task automatic load_img();
    ld_en = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic release_rst();
    base_pulse = pulse_cnt;
    base_wr    = wr_cnt;
    reset      = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_v(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: got %h but no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e)
      else begin
        miscompares++;
        $error("FAIL %s: got %h expected %h", tag, obs, e);
      end
    end
  endtask

  initial begin
    reset       = 1'b0;
    ld_en       = 1'b0;
    vectors     = 0;
    miscompares = 0;
    base_pulse  = 0;
    base_wr     = 0;
    @(negedge clk);

    // T1: reset state, CLS, LD/ADD immediate, skip, jump-to-self
    begin_test();
    poke(12'h200, 16'h00E0); poke(12'h202, 16'h6005); poke(12'h204, 16'h7001);
    poke(12'h206, 16'h3006); poke(12'h208, 16'h1204); poke(12'h20A, 16'h120A);
    load_img();
    expect_v(64'h200); expect_v(64'h200); expect_v(64'h0); expect_v(64'h0);
    expect_v(64'h0);   expect_v(64'h0);   expect_v(64'h0); expect_v(64'h0);
    expect_v(64'h05);  expect_v(64'h06);  expect_v(64'h20A); expect_v(64'd1);
    check("rst_pc",       64'(dut.pc));
    check("rst_mem_addr", 64'(mem_addr));
    check("rst_wr_en",    64'(mem_write_en));
    check("rst_wr_data",  64'(mem_write_data));
    check("rst_disp",     64'(display_update));
    check("rst_sp",       64'(dut.sp));
    check("rst_delay",    64'(delay_timer_out));
    check("rst_state",    64'(dbg_state));
    release_rst();
    run(6);  check("t1_v0_ld",  64'(dut.V[0]));
    run(3);  check("t1_v0_add", 64'(dut.V[0]));
    run(30); check("t1_pc_hold", 64'(dut.pc));
    check("t1_cls_pulses", 64'(pulse_cnt - base_pulse));

    // T2: ALU flags, including VF as destination
    begin_test();
    poke(12'h200, 16'h60FF); poke(12'h202, 16'h6101); poke(12'h204, 16'h8014);
    poke(12'h206, 16'h6003); poke(12'h208, 16'h6105); poke(12'h20A, 16'h8015);
    poke(12'h20C, 16'h6081); poke(12'h20E, 16'h8006);
    poke(12'h210, 16'h6F80); poke(12'h212, 16'h8FFE);
    load_img(); release_rst();
    expect_v(64'h00); expect_v(64'h01); expect_v(64'hFE); expect_v(64'h00);
    expect_v(64'h40); expect_v(64'h01); expect_v(64'h01);
    run(9); check("t2_add_v0", 64'(dut.V[0])); check("t2_add_vf", 64'(dut.V[15]));
    run(9); check("t2_sub_v0", 64'(dut.V[0])); check("t2_sub_vf", 64'(dut.V[15]));
    run(6); check("t2_shr_v0", 64'(dut.V[0])); check("t2_shr_vf", 64'(dut.V[15]));
    run(6); check("t2_shl_vf_flag_wins", 64'(dut.V[15]));

    // T3: CALL / RET
    begin_test();
    poke(12'h200, 16'h2300); poke(12'h300, 16'h00EE);
    load_img(); release_rst();
    expect_v(64'h300); expect_v(64'd1); expect_v(64'h200); expect_v(64'h202); expect_v(64'd0);
    run(3); check("t3_call_pc", 64'(dut.pc)); check("t3_call_sp", 64'(dut.sp));
    check("t3_stack0", 64'(dut.stack[0]));
    run(3); check("t3_ret_pc", 64'(dut.pc)); check("t3_ret_sp", 64'(dut.sp));

    // T4: draw twice at origin (set then collide/erase)
    begin_test();
    poke(12'h200, 16'hA300); poke(12'h202, 16'h6000); poke(12'h204, 16'h6100);
    poke(12'h206, 16'hD011); poke(12'h208, 16'hD011);
    ld_img[12'h300] = 8'hF0;
    load_img(); release_rst();
    expect_v(64'd1); expect_v(64'hF000_0000_0000_0000); expect_v(64'h0);
    expect_v(64'd0); expect_v(64'h0); expect_v(64'h1); expect_v(64'd2);
    run(13); check("t4_pulse_time", 64'(display_update));
    check("t4_row0_set", dut.display_pixels[0]); check("t4_vf_nocoll", 64'(dut.V[15]));
    run(1);  check("t4_pulse_end", 64'(display_update));
    run(5);  check("t4_row0_clr", dut.display_pixels[0]); check("t4_vf_coll", 64'(dut.V[15]));
    check("t4_pulses", 64'(pulse_cnt - base_pulse));

    // T5: draw wrapping both columns and rows
    begin_test();
    poke(12'h200, 16'hA300); poke(12'h202, 16'h603C); poke(12'h204, 16'h611F);
    poke(12'h206, 16'hD012);
    ld_img[12'h300] = 8'hF0; ld_img[12'h301] = 8'h81;
    load_img(); release_rst();
    expect_v(64'h0000_0000_0000_000F); expect_v(64'h1000_0000_0000_0008); expect_v(64'h0);
    run(15); check("t5_row31", dut.display_pixels[31]);
    check("t5_row0_wrap", dut.display_pixels[0]); check("t5_vf", 64'(dut.V[15]));

    // T6: register store / load
    begin_test();
    poke(12'h200, 16'hA400); poke(12'h202, 16'h600A); poke(12'h204, 16'h610B);
    poke(12'h206, 16'hF155); poke(12'h208, 16'h6000); poke(12'h20A, 16'h6100);
    poke(12'h20C, 16'hF165);
    load_img(); release_rst();
    expect_v(64'd2); expect_v(64'h0A); expect_v(64'h0B);
    expect_v(64'h0A); expect_v(64'h0B); expect_v(64'h400); expect_v(64'd2);
    run(17); check("t6_wr_cycles", 64'(wr_cnt - base_wr));
    check("t6_mem400", 64'(mem[12'h400])); check("t6_mem401", 64'(mem[12'h401]));
    run(11); check("t6_ld_v0", 64'(dut.V[0])); check("t6_ld_v1", 64'(dut.V[1]));
    check("t6_i_kept", 64'(dut.I)); check("t6_no_extra_wr", 64'(wr_cnt - base_wr));

    // T7: register skips, BNNN, FX1E wrap
    begin_test();
    poke(12'h200, 16'h6105); poke(12'h202, 16'h6205); poke(12'h204, 16'h5120);
    poke(12'h206, 16'h6301); poke(12'h208, 16'h9120); poke(12'h20A, 16'h4106);
    poke(12'h20C, 16'h6402); poke(12'h20E, 16'h6010); poke(12'h210, 16'hB300);
    poke(12'h310, 16'hAFF0); poke(12'h312, 16'hF01E);
    load_img(); release_rst();
    expect_v(64'h208); expect_v(64'h310); expect_v(64'h0); expect_v(64'h0);
    expect_v(64'h10); expect_v(64'h000);
    run(9);  check("t7_skip_eq_pc", 64'(dut.pc));
    run(12); check("t7_bnnn_pc", 64'(dut.pc));
    check("t7_v3_skipped", 64'(dut.V[3])); check("t7_v4_skipped", 64'(dut.V[4]));
    check("t7_v0", 64'(dut.V[0]));
    run(6);  check("t7_i_wrap", 64'(dut.I));

    // T8: timers, write beats tick, FX07
    begin_test();
    poke(12'h200, 16'h6003); poke(12'h202, 16'hF015); poke(12'h204, 16'h6105);
    poke(12'h206, 16'hF118); poke(12'h208, 16'hF207);
    load_img(); release_rst();
    expect_v(64'd3); expect_v(64'd2); expect_v(64'd1); expect_v(64'd5);
    expect_v(64'd0); expect_v(64'd4); expect_v(64'd1); expect_v(64'd0); expect_v(64'd2);
    run(6); check("t8_delay_set", 64'(delay_timer_out));
    run(2); check("t8_delay_2", 64'(delay_timer_out));
    run(4); check("t8_delay_1", 64'(delay_timer_out)); check("t8_sound_wins", 64'(sound_timer_out));
    run(4); check("t8_delay_0", 64'(delay_timer_out)); check("t8_sound_4", 64'(sound_timer_out));
    check("t8_fx07", 64'(dut.V[2]));
    run(8); check("t8_delay_hold", 64'(delay_timer_out)); check("t8_sound_2", 64'(sound_timer_out));

    // T9: asynchronous reset in the middle of an instruction
    begin_test();
    poke(12'h200, 16'h6055);
    load_img(); release_rst();
    expect_v(64'h200); expect_v(64'h0); expect_v(64'h0); expect_v(64'h0); expect_v(64'h55);
    run(2);
    #2 reset = 1'b0;
    #1 check("t9_async_pc", 64'(dut.pc)); check("t9_async_state", 64'(dbg_state));
    @(negedge clk); check("t9_no_partial_v0", 64'(dut.V[0]));
    check("t9_v3_cleared", 64'(dut.V[3]));
    reset = 1'b1;
    run(3); check("t9_rerun_v0", 64'(dut.V[0]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
